// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline control unit for the five-stage Y86-64 core.
//
// Purpose:
//   Detects load/use, ret and mispredicted-jump hazards and drives the
//   stall/bubble controls of the F, D, E, M and W pipeline registers. It also
//   gates the execute-stage condition-code write. A run/pause/step/halt
//   sequencer and two saturating performance counters serve the debug
//   interface.
//
// Parameters:
//   CNT_W        width of cycle_cnt_o and hazard_cnt_o
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   D_icode_i, d_srcA_i, d_srcB_i   decode-stage icode and source registers
//   E_icode_i, E_dstM_i, e_cnd_i    execute-stage icode, load dest, condition
//   M_icode_i, m_stat_i             memory-stage icode and outgoing status
//   W_stat_i                        write-back status
//   pause_req_i, step_i             debugger pause level and single-step pulse
//   F/D/E/M/W_stall_o, *_bubble_o   pipeline register controls
//   set_cc_en_o                     permit CC update in execute
//   paused_o, halted_o              sequencer state flags
//   final_stat_o                    status that caused the halt
//   cycle_cnt_o, hazard_cnt_o       saturating performance counters
//
// Notes:
//   The stall/bubble controls are combinational in the current inputs and the
//   registered sequencer state. The pipeline registers sample them on the same
//   edge, so they cannot be delayed by a register stage.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    input  logic             pause_req_i,
    input  logic             step_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_stall_o,
    output logic             E_bubble_o,
    output logic             M_stall_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic             set_cc_en_o,
    output logic             paused_o,
    output logic             halted_o,
    output logic [2:0]       final_stat_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] hazard_cnt_o
);

    // Instruction codes referenced by the hazard logic.
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;

    // Status codes.
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Sequencer states.
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSED = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // True for the exception statuses. A status of 0 marks a bubble and is
    // deliberately not treated as an exception.
    function automatic logic is_exc(input logic [2:0] stat);
        logic res;
        case (stat)
            STAT_HLT: res = 1'b1;
            STAT_ADR: res = 1'b1;
            STAT_INS: res = 1'b1;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

    // True for instructions that write a register from memory.
    function automatic logic is_load(input logic [3:0] icode);
        logic res;
        case (icode)
            I_MRMOVQ: res = 1'b1;
            I_POPQ:   res = 1'b1;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [2:0]       final_stat_r;
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] hazard_cnt_r;

    logic             load_use_s;
    logic             ret_busy_s;
    logic             mispredict_s;
    logic             hazard_s;
    logic             m_exc_s;
    logic             w_exc_s;
    logic             advancing_s;
    logic             latch_halt_s;

    // Hazard detection terms. The RNONE guard keeps a load with no register
    // destination from matching an unused (RNONE) decode source.
    always_comb begin
        load_use_s   = is_load(E_icode_i) && (E_dstM_i != RNONE) &&
                       ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        ret_busy_s   = (D_icode_i == I_RET) || (E_icode_i == I_RET) ||
                       (M_icode_i == I_RET);
        mispredict_s = (E_icode_i == I_JXX) && !e_cnd_i;
        hazard_s     = load_use_s || ret_busy_s || mispredict_s;
        m_exc_s      = is_exc(m_stat_i);
        w_exc_s      = is_exc(W_stat_i);
        advancing_s  = (state_r == ST_RUN) || (state_r == ST_STEP);
        latch_halt_s = advancing_s && w_exc_s;
    end

    // Pipeline register controls: reset override, normal control while the
    // pipeline advances, otherwise frozen (everything held, nothing injected).
    always_comb begin
        F_stall_o   = 1'b0;
        D_stall_o   = 1'b0;
        D_bubble_o  = 1'b0;
        E_stall_o   = 1'b0;
        E_bubble_o  = 1'b0;
        M_stall_o   = 1'b0;
        M_bubble_o  = 1'b0;
        W_stall_o   = 1'b0;
        set_cc_en_o = 1'b0;
        if (rst_i) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
        end else if (advancing_s) begin
            F_stall_o   = load_use_s || ret_busy_s;
            D_stall_o   = load_use_s;
            // A load/use stall in D takes precedence over the ret bubble.
            D_bubble_o  = mispredict_s || (ret_busy_s && !load_use_s);
            E_bubble_o  = mispredict_s || load_use_s;
            M_bubble_o  = m_exc_s || w_exc_s;
            W_stall_o   = w_exc_s;
            set_cc_en_o = (E_icode_i == I_OPQ) && !m_exc_s && !w_exc_s;
        end else begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            E_stall_o = 1'b1;
            M_stall_o = 1'b1;
            W_stall_o = 1'b1;
        end
    end

    // Sequencer state flags, forced low while reset is asserted.
    always_comb begin
        paused_o     = 1'b0;
        halted_o     = 1'b0;
        final_stat_o = final_stat_r;
        cycle_cnt_o  = cycle_cnt_r;
        hazard_cnt_o = hazard_cnt_r;
        if (rst_i) begin
            paused_o = 1'b0;
            halted_o = 1'b0;
        end else begin
            paused_o = (state_r == ST_PAUSED);
            halted_o = (state_r == ST_HALTED);
        end
    end

    // Next-state logic of the run/pause/step/halt sequencer. Halt outranks
    // pause; in PAUSED a step pulse outranks releasing the pause.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN, ST_STEP: begin
                if (w_exc_s) begin
                    state_next_s = ST_HALTED;
                end else if (pause_req_i) begin
                    state_next_s = ST_PAUSED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (step_i) begin
                    state_next_s = ST_STEP;
                end else if (!pause_req_i) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSED;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // Sequencer state register and the halt-status latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_RUN;
            final_stat_r <= STAT_AOK;
        end else begin
            state_r <= state_next_s;
            if (latch_halt_s) begin
                final_stat_r <= W_stat_i;
            end else begin
                final_stat_r <= final_stat_r;
            end
        end
    end

    // Saturating performance counters; they only move on advancing cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_r  <= {CNT_W{1'b0}};
            hazard_cnt_r <= {CNT_W{1'b0}};
        end else if (advancing_s) begin
            if (cycle_cnt_r != CNT_MAX) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            if (hazard_s && (hazard_cnt_r != CNT_MAX)) begin
                hazard_cnt_r <= hazard_cnt_r + CNT_ONE;
            end else begin
                hazard_cnt_r <= hazard_cnt_r;
            end
        end else begin
            cycle_cnt_r  <= cycle_cnt_r;
            hazard_cnt_r <= hazard_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// A table of single-cycle vectors exercises the hazard controls in RUN; hand
// sequences cover reset, halt, pause/step and counter saturation (CNT_W=4).
// Control outputs are compared as a 9-bit vector:
//   {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble,
//    W_stall, set_cc_en}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic        e_cnd;
    logic [2:0]  m_stat, W_stat;
    logic        pause_req, step;

    logic F_stall, D_stall, D_bubble, E_stall, E_bubble;
    logic M_stall, M_bubble, W_stall, set_cc_en, paused, halted;
    logic [2:0]  final_stat;
    logic [31:0] cycle_cnt, hazard_cnt;

    // Second instance with narrow counters for the saturation check.
    logic        rst4;
    logic F4, D4s, D4b, E4s, E4b, M4s, M4b, W4, cc4, p4, h4;
    logic [2:0]  fs4;
    logic [3:0]  cyc4, haz4;

    logic [8:0]  ctrl;
    assign ctrl = {F_stall, D_stall, D_bubble, E_stall, E_bubble,
                   M_stall, M_bubble, W_stall, set_cc_en};

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cycle  = 0;
    int exp_hazard = 0;

    localparam logic [8:0] C_NONE  = 9'b000000000;
    localparam logic [8:0] C_LU    = 9'b110010000;
    localparam logic [8:0] C_RET   = 9'b101000000;
    localparam logic [8:0] C_MIS   = 9'b001010000;
    localparam logic [8:0] C_CC    = 9'b000000001;
    localparam logic [8:0] C_MB    = 9'b000000100;
    localparam logic [8:0] C_FROZE = 9'b110101010;
    localparam logic [8:0] C_RST   = 9'b001010100;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_cnd_i(e_cnd),
        .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat),
        .pause_req_i(pause_req), .step_i(step),
        .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble),
        .E_stall_o(E_stall), .E_bubble_o(E_bubble), .M_stall_o(M_stall),
        .M_bubble_o(M_bubble), .W_stall_o(W_stall), .set_cc_en_o(set_cc_en),
        .paused_o(paused), .halted_o(halted), .final_stat_o(final_stat),
        .cycle_cnt_o(cycle_cnt), .hazard_cnt_o(hazard_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst4),
        .D_icode_i(4'h1), .d_srcA_i(4'hF), .d_srcB_i(4'hF),
        .E_icode_i(4'h1), .E_dstM_i(4'hF), .e_cnd_i(1'b0),
        .M_icode_i(4'h1), .m_stat_i(3'd1), .W_stat_i(3'd1),
        .pause_req_i(1'b0), .step_i(1'b0),
        .F_stall_o(F4), .D_stall_o(D4s), .D_bubble_o(D4b),
        .E_stall_o(E4s), .E_bubble_o(E4b), .M_stall_o(M4s),
        .M_bubble_o(M4b), .W_stall_o(W4), .set_cc_en_o(cc4),
        .paused_o(p4), .halted_o(h4), .final_stat_o(fs4),
        .cycle_cnt_o(cyc4), .hazard_cnt_o(haz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d_icode;
        logic [3:0] srca;
        logic [3:0] srcb;
        logic [3:0] e_icode;
        logic [3:0] e_dstm;
        logic       cnd;
        logic [3:0] m_icode;
        logic [2:0] mst;
        logic [8:0] exp_ctrl;
        logic       hz;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_cnd = 1'b0;
        M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
        pause_req = 1'b0; step = 1'b0;
    endtask

    task automatic set_load_use();
        set_idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 D    sA   sB   E    dstM cnd  M    mst  ctrl    hz
        tbl[0]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, C_NONE, 1'b0};
        tbl[1]  = '{4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h1, 3'd1, C_LU,   1'b1};
        tbl[2]  = '{4'h1, 4'h3, 4'hF, 4'h5, 4'hF, 1'b0, 4'h1, 3'd1, C_NONE, 1'b0};
        tbl[3]  = '{4'h1, 4'h2, 4'h4, 4'hB, 4'h4, 1'b0, 4'h1, 3'd1, C_LU,   1'b1};
        tbl[4]  = '{4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, C_RET,  1'b1};
        tbl[5]  = '{4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b0, 4'h1, 3'd1, C_RET,  1'b1};
        tbl[6]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h9, 3'd1, C_RET,  1'b1};
        tbl[7]  = '{4'h9, 4'h2, 4'hF, 4'h5, 4'h2, 1'b0, 4'h1, 3'd1, C_LU,   1'b1};
        tbl[8]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, C_MIS,  1'b1};
        tbl[9]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, C_NONE, 1'b0};
        tbl[10] = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd1, C_CC,   1'b0};
        tbl[11] = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd3, C_MB,   1'b0};
        tbl[12] = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd0, C_CC,   1'b0};
        tbl[13] = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h9, 3'd1, 9'b101010000, 1'b1};
        tbl[14] = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd2, C_MB,   1'b0};

        // Reset behaviour.
        set_idle();
        rst = 1'b1; rst4 = 1'b1;
        tick();
        check("rst_ctrl", {23'd0, ctrl}, {23'd0, C_RST});
        check("rst_paused", {31'd0, paused}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_hazard", hazard_cnt, 32'd0);
        check("rst_final", {29'd0, final_stat}, 32'd1);
        rst = 1'b0;
        #1;
        check("run_idle_ctrl", {23'd0, ctrl}, {23'd0, C_NONE});

        // Table-driven hazard vectors in RUN.
        for (int i = 0; i < 15; i++) begin
            D_icode = tbl[i].d_icode; d_srcA = tbl[i].srca; d_srcB = tbl[i].srcb;
            E_icode = tbl[i].e_icode; E_dstM = tbl[i].e_dstm; e_cnd = tbl[i].cnd;
            M_icode = tbl[i].m_icode; m_stat = tbl[i].mst; W_stat = 3'd1;
            #1;
            check($sformatf("vec%0d_ctrl", i), {23'd0, ctrl}, {23'd0, tbl[i].exp_ctrl});
            tick();
            exp_cycle++;
            if (tbl[i].hz) exp_hazard++;
            check($sformatf("vec%0d_cycle", i), cycle_cnt, exp_cycle);
            check($sformatf("vec%0d_hazard", i), hazard_cnt, exp_hazard);
        end

        // Exception reaches write-back, then halt.
        set_idle();
        E_icode = 4'h6; m_stat = 3'd3;
        #1;
        check("halt_m_ctrl", {23'd0, ctrl}, {23'd0, C_MB});
        tick();
        exp_cycle++;
        set_idle();
        W_stat = 3'd3;
        #1;
        check("halt_w_ctrl", {23'd0, ctrl}, {23'd0, 9'b000000110});
        check("halt_w_not_yet", {31'd0, halted}, 32'd0);
        tick();
        exp_cycle++;
        check("halted", {31'd0, halted}, 32'd1);
        check("final_stat", {29'd0, final_stat}, 32'd3);
        check("halt_cycle", cycle_cnt, exp_cycle);
        set_load_use();
        pause_req = 1'b1; step = 1'b1;
        #1;
        check("halt_frozen_ctrl", {23'd0, ctrl}, {23'd0, C_FROZE});
        check("halt_not_paused", {31'd0, paused}, 32'd0);
        repeat (3) tick();
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("halt_cycle_frozen", cycle_cnt, exp_cycle);
        check("halt_hazard_frozen", hazard_cnt, exp_hazard);
        rst = 1'b1;
        #1;
        check("halt_rst_ctrl", {23'd0, ctrl}, {23'd0, C_RST});
        check("halt_rst_flag", {31'd0, halted}, 32'd0);
        tick();
        exp_cycle = 0; exp_hazard = 0;
        check("halt_rst_cycle", cycle_cnt, 32'd0);
        check("halt_rst_hazard", hazard_cnt, 32'd0);
        check("halt_rst_final", {29'd0, final_stat}, 32'd1);
        rst = 1'b0;
        set_idle();
        #1;
        check("after_rst_halted", {31'd0, halted}, 32'd0);
        check("after_rst_ctrl", {23'd0, ctrl}, {23'd0, C_NONE});

        // Pause, single step, release.
        pause_req = 1'b1;
        #1;
        check("pause_req_ctrl", {23'd0, ctrl}, {23'd0, C_NONE});
        tick();
        exp_cycle++;
        check("paused", {31'd0, paused}, 32'd1);
        set_load_use();
        pause_req = 1'b1;
        #1;
        check("paused_ctrl", {23'd0, ctrl}, {23'd0, C_FROZE});
        tick();
        check("paused_cycle", cycle_cnt, exp_cycle);
        step = 1'b1;
        #1;
        check("step_req_ctrl", {23'd0, ctrl}, {23'd0, C_FROZE});
        tick();
        step = 1'b0;
        #1;
        check("step_not_paused", {31'd0, paused}, 32'd0);
        check("step_ctrl", {23'd0, ctrl}, {23'd0, C_LU});
        tick();
        exp_cycle++; exp_hazard++;
        check("step_repaused", {31'd0, paused}, 32'd1);
        check("step_cycle", cycle_cnt, exp_cycle);
        check("step_hazard", hazard_cnt, exp_hazard);
        set_idle();
        #1;
        check("release_ctrl", {23'd0, ctrl}, {23'd0, C_FROZE});
        tick();
        check("release_run", {31'd0, paused}, 32'd0);
        #1;
        check("release_run_ctrl", {23'd0, ctrl}, {23'd0, C_NONE});

        // Counter saturation with CNT_W = 4.
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        check("sat_rst", {28'd0, cyc4}, 32'd0);
        repeat (14) tick();
        check("sat_14", {28'd0, cyc4}, 32'd14);
        tick();
        check("sat_15", {28'd0, cyc4}, 32'd15);
        repeat (5) tick();
        check("sat_hold", {28'd0, cyc4}, 32'd15);
        check("sat_hazard", {28'd0, haz4}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
